// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and settle timing.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Cycles a vector is held before its results are sampled.
    localparam int unsigned SETTLE_CYCLES = 1;

endpackage

// File: rtl/mismatch_tracker.sv
// Accumulates mismatch statistics for one sweep: count plus first failing vector.
module mismatch_tracker #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         check,
    input  logic         mismatch,
    input  logic [N-1:0] vec,
    output logic [N:0]   mm_count,
    output logic [N-1:0] first_fail,
    output logic         first_fail_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mm_count         <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            mm_count         <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (check && mismatch) begin
            // N+1 bits hold all 2^N mismatches, so no saturation is needed
            mm_count <= mm_count + (N+1)'(1);
            if (!first_fail_valid) begin
                first_fail       <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every N-bit vector into two implementations of one function and
// reports whether their outputs agree on all of them.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] vec,
    input  logic         res_gate,
    input  logic         res_expr,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   mm_count,
    output logic [N-1:0] first_fail,
    output logic         first_fail_valid
);

    state_t state;
    logic   accept;
    logic   last_vec;

    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_vec = (vec == {N{1'b1}});

    // Sequencer: APPLY holds vec for settling, CHECK samples and advances.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            vec   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_APPLY;
                        vec   <= '0;
                    end
                end
                ST_APPLY: state <= ST_CHECK;
                ST_CHECK: begin
                    if (last_vec) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_APPLY;
                        vec   <= vec + N'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status is decoded from registered state only; res_* never reach outputs.
    assign busy = (state == ST_APPLY) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (mm_count == '0);

    mismatch_tracker #(.N(N)) u_tracker (
        .clk              (clk),
        .reset            (reset),
        .clear            (accept),
        .check            (state == ST_CHECK),
        .mismatch         (res_gate ^ res_expr),
        .vec              (vec),
        .mm_count         (mm_count),
        .first_fail       (first_fail),
        .first_fail_valid (first_fail_valid)
    );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: expected sweep results are queued at start, checked when done rises.
module tb_truth_table_sweeper;
    import truth_table_pkg::*;

    typedef struct {
        int mm;
        int ff;
        int ffv;
        int ps;
        int lat;
        int t0;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    exp_t q2[$];
    exp_t q3[$];

    // N=2 instance: a=vec[1], b=vec[0]
    logic       start2 = 1'b0;
    logic       mode2  = 1'b0;
    logic [1:0] vec2;
    logic       gate2, expr2, busy2, done2, pass2, ffv2;
    logic [2:0] mm2;
    logic [1:0] ff2;
    assign gate2 = vec2[1] & ~vec2[0];
    assign expr2 = mode2 ? (~vec2[1] & vec2[0]) : (vec2[1] & ~vec2[0]);

    truth_table_sweeper #(.N(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .vec(vec2),
        .res_gate(gate2), .res_expr(expr2), .busy(busy2), .done(done2),
        .pass(pass2), .mm_count(mm2), .first_fail(ff2), .first_fail_valid(ffv2)
    );

    // N=3 instance: the two units always disagree
    logic       start3 = 1'b0;
    logic [2:0] vec3;
    logic       gate3, expr3, busy3, done3, pass3, ffv3;
    logic [3:0] mm3;
    logic [2:0] ff3;
    assign expr3 = ^vec3;
    assign gate3 = ~expr3;

    truth_table_sweeper #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .vec(vec3),
        .res_gate(gate3), .res_expr(expr3), .busy(busy3), .done(done3),
        .pass(pass3), .mm_count(mm3), .first_fail(ff3), .first_fail_valid(ffv3)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int mm, input int ff, input int ffv, input int ps, input int n);
        exp_t e;
        e.mm  = mm;
        e.ff  = ff;
        e.ffv = ffv;
        e.ps  = ps;
        e.lat = int'(SETTLE_CYCLES + 1) * (1 << n);
        e.t0  = 0;
        return e;
    endfunction

    // Monitors: pop the oldest expectation when done rises
    logic done2_q = 1'b0;
    always @(negedge clk) begin
        if (done2 && !done2_q) begin
            check("sb2_pending", int'(q2.size() > 0), 1);
            if (q2.size() > 0) begin
                exp_t e;
                e = q2.pop_front();
                check("n2_mm_count", int'(mm2), e.mm);
                check("n2_first_fail", int'(ff2), e.ff);
                check("n2_first_fail_valid", int'(ffv2), e.ffv);
                check("n2_pass", int'(pass2), e.ps);
                check("n2_latency", cyc - e.t0, e.lat);
                check("n2_busy_low", int'(busy2), 0);
            end
        end
        done2_q = done2;
    end

    logic done3_q = 1'b0;
    always @(negedge clk) begin
        if (done3 && !done3_q) begin
            check("sb3_pending", int'(q3.size() > 0), 1);
            if (q3.size() > 0) begin
                exp_t e;
                e = q3.pop_front();
                check("n3_mm_count", int'(mm3), e.mm);
                check("n3_first_fail", int'(ff3), e.ff);
                check("n3_first_fail_valid", int'(ffv3), e.ffv);
                check("n3_pass", int'(pass3), e.ps);
                check("n3_latency", cyc - e.t0, e.lat);
            end
        end
        done3_q = done3;
    end

    task automatic issue2(input exp_t e_in);
        exp_t e;
        e = e_in;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        e.t0 = cyc;
        q2.push_back(e);
        check("n2_accept_busy", int'(busy2), 1);
        check("n2_accept_vec", int'(vec2), 0);
        check("n2_accept_mm_clear", int'(mm2), 0);
        check("n2_accept_ffv_clear", int'(ffv2), 0);
    endtask

    task automatic wait_done2(input int budget);
        int n = 0;
        while (!done2 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("n2_done_timeout", int'(done2), 1);
    endtask

    initial begin
        #12;
        check("rst_vec", int'(vec2), 0);
        check("rst_busy", int'(busy2), 0);
        check("rst_done", int'(done2), 0);
        check("rst_pass", int'(pass2), 0);
        check("rst_mm", int'(mm2), 0);
        check("rst_ffv", int'(ffv2), 0);
        @(negedge clk);
        reset = 1'b0;

        // matching units
        mode2 = 1'b0;
        issue2(mk(0, 0, 0, 1, 2));
        wait_done2(40);

        // a&~b versus ~a&b: disagree on 01 and 10
        mode2 = 1'b1;
        issue2(mk(2, 1, 1, 0, 2));
        wait_done2(40);

        // start pulsed during CHECK of vector 01 is ignored
        issue2(mk(2, 1, 1, 0, 2));
        repeat (3) @(posedge clk);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("ignored_start_vec", int'(vec2), 2);
        wait_done2(40);

        // failing result cleared by a new matching sweep
        mode2 = 1'b0;
        issue2(mk(0, 0, 0, 1, 2));
        wait_done2(40);

        // async reset during APPLY of vector 10
        mode2 = 1'b1;
        issue2(mk(2, 1, 1, 0, 2));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_vec", int'(vec2), 2);
        check("pre_reset_mm", int'(mm2), 1);
        reset = 1'b1;
        #1;
        void'(q2.pop_back());
        check("abort_vec", int'(vec2), 0);
        check("abort_busy", int'(busy2), 0);
        check("abort_done", int'(done2), 0);
        check("abort_mm", int'(mm2), 0);
        check("abort_ff", int'(ff2), 0);
        check("abort_ffv", int'(ffv2), 0);
        @(negedge clk);
        reset = 1'b0;
        mode2 = 1'b0;
        issue2(mk(0, 0, 0, 1, 2));
        wait_done2(40);

        // N=3, every vector mismatches: count reaches 8 without overflow
        begin
            exp_t e;
            int n = 0;
            e = mk(8, 0, 1, 0, 3);
            @(negedge clk);
            start3 = 1'b1;
            @(posedge clk);
            #1;
            start3 = 1'b0;
            e.t0 = cyc;
            q3.push_back(e);
            check("n3_accept_busy", int'(busy3), 1);
            while (!done3 && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("n3_done_timeout", int'(done3), 1);
        end

        repeat (2) @(negedge clk);
        check("sb2_drained", q2.size(), 0);
        check("sb3_drained", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
